shift_divider: RTL and testbench
================================

SHIFT_DIVIDER -- requirements
Module: shift_divider

Interface
REQ-001 Parameter: n, default 4, operand/result width in bits (n >= 2).
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  begin-operation request (IDLE) / acknowledge-result (STOPPED).
REQ-005 dividend  input  n  unsigned dividend, sampled only on the load edge.
REQ-006 divisor  input  n  unsigned divisor, sampled only on the load edge.
REQ-007 quotient  output  n  unsigned quotient, valid while ready=1.
REQ-008 remainder  output  n  unsigned remainder, valid while ready=1.
REQ-009 div_by_zero  output  1  high while ready=1 if the loaded divisor was 0.
REQ-010 busy  output  1  high in SHIFTING and SUBTRACTING.
REQ-011 ready  output  1  high in STOPPED only.

Function
REQ-012 Algorithm SHALL be restoring shift-subtract division, one quotient bit per SHIFTING+SUBTRACTING pair.
REQ-013 Internal registers: A (n+1 bits, partial remainder), Q (n bits), M (n bits), count ($clog2(n+1) bits), dz flag; state in {IDLE, SHIFTING, SUBTRACTING, STOPPED}.
REQ-014 IDLE, start=1, divisor!=0: load A=0, Q=dividend, M=divisor, count=n, dz=0; next state SHIFTING.
REQ-015 IDLE, start=1, divisor=0: load A={1'b0,dividend}, Q=all ones, dz=1; next state STOPPED directly.
REQ-016 IDLE, start=0: hold all registers, stay IDLE.
REQ-017 SHIFTING: {A,Q} shifted left by one, Q[0]=0; next state SUBTRACTING.
REQ-018 SUBTRACTING: if A >= {1'b0,M}: A=A-M, Q[0]=1; else A unchanged, Q[0]=0; count=count-1.
REQ-019 SUBTRACTING: if count==1 before decrement, next state STOPPED; else SHIFTING.
REQ-020 Compare and subtract SHALL be n+1-bit unsigned; A SHALL never exceed 2*M-1 after shift, so no overflow occurs.
REQ-021 STOPPED: hold A, Q, dz; start=1 moves to IDLE (one cycle, no load); start=0 stays STOPPED indefinitely.
REQ-022 start SHALL be ignored in SHIFTING and SUBTRACTING.
REQ-023 Latency: with load edge counted as edge 1, ready SHALL first be high after edge 2n+1 (n=4: 9 edges); divide-by-zero: after edge 1.
REQ-024 A new operation requires STOPPED->IDLE (start) and a further start in IDLE; back-to-back start held high SHALL cycle STOPPED->IDLE->load.
REQ-025 quotient=Q, remainder=A[n-1:0], div_by_zero=dz continuously; values SHALL only be relied on while ready=1.
REQ-026 Outputs busy/ready SHALL be decoded combinationally from state only, no dependency on start.
REQ-027 Results SHALL satisfy dividend = quotient*divisor + remainder, remainder < divisor, for all divisor != 0.

Reset
REQ-028 reset=1 at a rising edge SHALL force state IDLE, A=0, Q=0, M=0, count=0, dz=0, from any state.
REQ-029 reset SHALL dominate start on the same edge; an in-progress division is abandoned, no result produced.
REQ-030 After reset: quotient=0, remainder=0, div_by_zero=0, busy=0, ready=0.

Verification
REQ-031 n=4, dividend=13, divisor=4, start 1 cycle -> busy for 8 cycles, ready after edge 9, quotient=3, remainder=1, div_by_zero=0.
REQ-032 n=4, 15/1 -> quotient=15, remainder=0; 5/7 -> quotient=0, remainder=5; 0/3 -> quotient=0, remainder=0.
REQ-033 n=4, 9/0 -> ready after edge 1, div_by_zero=1, quotient=15, remainder=9, busy never high.
REQ-034 n=4, start 13/4, reset=1 on edge 5 with start=1 -> IDLE, all outputs 0, no ready; fresh 14/3 then yields 4 r 2.
REQ-035 n=4, start and operand changes during busy -> ignored, result of original operands; n=8, 255/16 -> 15 r 15 after 17 edges.
REQ-036 Exhaustive n=4 sweep of all 256 operand pairs via STOPPED->IDLE->start sequencing -> REQ-027 holds, divisor=0 cases per REQ-015.

Source files
------------

// File: rtl/shift_divider_if.sv
// shift_divider_if: operand/result/status bundle between a requester and the divider.
interface shift_divider_if #(parameter int n = 4);
    logic         start;
    logic [n-1:0] dividend;
    logic [n-1:0] divisor;
    logic [n-1:0] quotient;
    logic [n-1:0] remainder;
    logic         div_by_zero;
    logic         busy;
    logic         ready;
    modport master (output start, dividend, divisor, input quotient, remainder, div_by_zero, busy, ready);
    modport slave  (input start, dividend, divisor, output quotient, remainder, div_by_zero, busy, ready);
endinterface

// File: rtl/shift_divider.sv
// shift_divider: restoring shift-subtract unsigned divider, one quotient bit per shift/subtract pair.
module shift_divider #(parameter int n = 4) (
    input logic clock,
    input logic reset,
    shift_divider_if.slave bus
);
    localparam int cw = $clog2(n + 1);
    typedef enum logic [1:0] {IDLE, SHIFTING, SUBTRACTING, STOPPED} state_t;
    state_t        state;
    logic [n:0]    a;
    logic [n-1:0]  q;
    logic [n-1:0]  m;
    logic [cw-1:0] count;
    logic          dz;
    logic [n:0]    diff;
    logic          ge;
    assign diff = a - {1'b0, m};
    assign ge   = a >= {1'b0, m};
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            a     <= '0;
            q     <= '0;
            m     <= '0;
            count <= '0;
            dz    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    m <= bus.divisor;
                    if (bus.divisor != '0) begin
                        a     <= '0;
                        q     <= bus.dividend;
                        count <= cw'(n);
                        dz    <= 1'b0;
                        state <= SHIFTING;
                    end else begin
                        // divide-by-zero: quotient saturates, remainder echoes the dividend
                        a     <= {1'b0, bus.dividend};
                        q     <= '1;
                        dz    <= 1'b1;
                        state <= STOPPED;
                    end
                end
                SHIFTING: begin
                    {a, q} <= {a[n-1:0], q, 1'b0};
                    state  <= SUBTRACTING;
                end
                SUBTRACTING: begin
                    if (ge) begin
                        a    <= diff;
                        q[0] <= 1'b1;
                    end
                    count <= count - cw'(1);
                    state <= (count == cw'(1)) ? STOPPED : SHIFTING;
                end
                STOPPED: if (bus.start) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.quotient    = q;
    assign bus.remainder   = a[n-1:0];
    assign bus.div_by_zero = dz;
    assign bus.busy        = (state == SHIFTING) || (state == SUBTRACTING);
    assign bus.ready       = (state == STOPPED);
endmodule

// File: tb/tb_shift_divider.sv
// tb_shift_divider: directed and exhaustive checks of shift_divider at n=4, plus one n=8 case.
module tb_shift_divider;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int edges;
    int bc;
    always #5 clock = ~clock;
    shift_divider_if #(.n(4)) b4 ();
    shift_divider_if #(.n(8)) b8 ();
    shift_divider #(.n(4)) dut4 (.clock(clock), .reset(reset), .bus(b4.slave));
    shift_divider #(.n(8)) dut8 (.clock(clock), .reset(reset), .bus(b8.slave));
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic wait_ready4();
        while (!b4.ready && edges < 40) begin
            tick();
            edges++;
            bc += int'(b4.busy);
        end
    endtask
    task automatic div4(input logic [3:0] dd, input logic [3:0] ds, input int lat,
                        input logic [3:0] eq, input logic [3:0] er, input logic edz, input string tag);
        b4.start = 1'b1;
        b4.dividend = dd;
        b4.divisor = ds;
        tick();
        b4.start = 1'b0;
        edges = 1;
        bc = int'(b4.busy);
        wait_ready4();
        chk({tag, " latency"}, edges, lat);
        chk({tag, " busy_cycles"}, bc, lat - 1);
        chk({tag, " quotient"}, b4.quotient, eq);
        chk({tag, " remainder"}, b4.remainder, er);
        chk({tag, " div_by_zero"}, b4.div_by_zero, edz);
        b4.start = 1'b1;
        tick();
        chk({tag, " ack_ready"}, b4.ready, 1'b0);
        b4.start = 1'b0;
    endtask
    initial begin
        b4.start = 1'b0; b4.dividend = '0; b4.divisor = '0;
        b8.start = 1'b0; b8.dividend = '0; b8.divisor = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst quotient", b4.quotient, 0);
        chk("rst remainder", b4.remainder, 0);
        chk("rst dz", b4.div_by_zero, 0);
        chk("rst busy", b4.busy, 0);
        chk("rst ready", b4.ready, 0);
        chk("rst8 ready", b8.ready, 0);
        div4(4'd13, 4'd4, 9, 4'd3, 4'd1, 1'b0, "13/4");
        div4(4'd15, 4'd1, 9, 4'd15, 4'd0, 1'b0, "15/1");
        div4(4'd5, 4'd7, 9, 4'd0, 4'd5, 1'b0, "5/7");
        div4(4'd0, 4'd3, 9, 4'd0, 4'd0, 1'b0, "0/3");
        div4(4'd9, 4'd0, 1, 4'd15, 4'd9, 1'b1, "9/0");
        // reset on edge 5 abandons the division even with start asserted
        b4.start = 1'b1; b4.dividend = 4'd13; b4.divisor = 4'd4;
        tick();
        b4.start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1; b4.start = 1'b1;
        tick();
        chk("rstmid busy", b4.busy, 0);
        chk("rstmid ready", b4.ready, 0);
        chk("rstmid quotient", b4.quotient, 0);
        chk("rstmid remainder", b4.remainder, 0);
        chk("rstmid dz", b4.div_by_zero, 0);
        reset = 1'b0; b4.start = 1'b0;
        tick();
        chk("rstmid idle ready", b4.ready, 0);
        div4(4'd14, 4'd3, 9, 4'd4, 4'd2, 1'b0, "14/3");
        // start and operands wiggle while busy; result must track the loaded 13/4
        b4.start = 1'b1; b4.dividend = 4'd13; b4.divisor = 4'd4;
        tick();
        edges = 1;
        bc = 1;
        repeat (5) begin
            b4.start = 1'($urandom);
            b4.dividend = 4'($urandom);
            b4.divisor = 4'($urandom);
            tick();
            edges++;
            bc += int'(b4.busy);
        end
        b4.start = 1'b0;
        wait_ready4();
        chk("noise latency", edges, 9);
        chk("noise quotient", b4.quotient, 3);
        chk("noise remainder", b4.remainder, 1);
        b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        // start held high: STOPPED -> IDLE -> fresh load
        b4.start = 1'b1; b4.dividend = 4'd5; b4.divisor = 4'd7;
        repeat (9) tick();
        chk("b2b ready", b4.ready, 1);
        chk("b2b quotient", b4.quotient, 0);
        chk("b2b remainder", b4.remainder, 5);
        tick();
        chk("b2b idle ready", b4.ready, 0);
        chk("b2b idle busy", b4.busy, 0);
        tick();
        chk("b2b reload busy", b4.busy, 1);
        b4.start = 1'b0;
        edges = 1;
        bc = 1;
        wait_ready4();
        chk("b2b2 latency", edges, 9);
        chk("b2b2 remainder", b4.remainder, 5);
        b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        b8.start = 1'b1; b8.dividend = 8'd255; b8.divisor = 8'd16;
        tick();
        b8.start = 1'b0;
        edges = 1;
        while (!b8.ready && edges < 60) begin
            tick();
            edges++;
        end
        chk("n8 latency", edges, 17);
        chk("n8 quotient", b8.quotient, 15);
        chk("n8 remainder", b8.remainder, 15);
        chk("n8 dz", b8.div_by_zero, 0);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                div4(i[3:0], j[3:0], (j == 0) ? 1 : 9,
                     (j == 0) ? 4'd15 : 4'(i / j), (j == 0) ? i[3:0] : 4'(i % j),
                     j == 0, $sformatf("sweep %0d/%0d", i, j));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
